// File: rtl/uart_tx_arbiter.sv
// Packet-locked round-robin arbiter that shares one UART byte transmitter
// between NUM_REQ byte-stream requesters, with forced release of idle locks.
`timescale 1ns/1ps
module uart_tx_arbiter #(
  parameter int NUM_REQ      = 2,
  parameter int LOCK_TIMEOUT = 1_000_000,
  parameter int TO_W         = 20
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NUM_REQ-1:0]   req_valid,
  input  logic [8*NUM_REQ-1:0] req_data,
  input  logic [NUM_REQ-1:0]   req_last,
  output logic [NUM_REQ-1:0]   req_ready,
  output logic [NUM_REQ-1:0]   grant,
  output logic                 tx_start,
  output logic [7:0]           tx_data,
  input  logic                 tx_busy,
  output logic                 lock_timeout,
  output logic [1:0]           dbg_state
);

  localparam int                IDX_W    = (NUM_REQ > 2) ? 2 : 1;
  localparam logic [TO_W-1:0]   TO_LAST  = TO_W'(LOCK_TIMEOUT - 1);
  localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(NUM_REQ - 1);

  typedef enum logic [1:0] {
    S_IDLE       = 2'd0,
    S_SEND       = 2'd1,
    S_WAIT_START = 2'd2,
    S_WAIT_DONE  = 2'd3
  } state_t;

  state_t             r_state, w_state_nxt;
  logic [NUM_REQ-1:0] r_grant, w_grant_nxt;
  logic [IDX_W-1:0]   r_owner, w_owner_nxt;
  logic [IDX_W-1:0]   r_last_grant, w_last_grant_nxt;
  logic [TO_W-1:0]    r_cnt, w_cnt_nxt;
  logic               r_last_flag, w_last_flag_nxt;
  logic               r_tx_start, w_tx_start_nxt;
  logic [7:0]         r_tx_data, w_tx_data_nxt;
  logic               r_lock_to, w_lock_to_nxt;

  logic [IDX_W:0]     w_pick;
  logic [7:0]         w_owner_data;
  logic               w_hs;

  // First valid requester after 'last', wrapping; MSB of the result is "found".
  function automatic logic [IDX_W:0] rr_pick(input logic [NUM_REQ-1:0] v,
                                             input logic [IDX_W-1:0]   last);
    logic [IDX_W:0] res;
    int             idx;
    res = '0;
    for (int k = NUM_REQ; k >= 1; k--) begin
      idx = (int'(last) + k) % NUM_REQ;
      if (v[IDX_W'(idx)]) res = {1'b1, IDX_W'(idx)};
    end
    return res;
  endfunction

  assign w_pick       = rr_pick(req_valid, r_last_grant);
  assign w_owner_data = req_data[{r_owner, 3'b000} +: 8];

  // Handshake: a byte moves when req_valid[g] and req_ready[g] are both high on
  // a clock edge; ready only rises for the owner in SEND while the UART is free.
  assign w_hs = (r_state == S_SEND) & req_valid[r_owner] & ~tx_busy;

  always_comb begin
    req_ready = '0;
    if (r_state == S_SEND && !tx_busy) req_ready = r_grant & req_valid;
  end

  always_comb begin
    w_state_nxt      = r_state;
    w_grant_nxt      = r_grant;
    w_owner_nxt      = r_owner;
    w_last_grant_nxt = r_last_grant;
    w_cnt_nxt        = r_cnt;
    w_last_flag_nxt  = r_last_flag;
    w_tx_start_nxt   = 1'b0;
    w_tx_data_nxt    = r_tx_data;
    w_lock_to_nxt    = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_cnt_nxt = '0;
        if (w_pick[IDX_W]) begin
          w_owner_nxt = w_pick[IDX_W-1:0];
          w_grant_nxt = NUM_REQ'(1) << w_pick[IDX_W-1:0];
          w_state_nxt = S_SEND;
        end
      end
      S_SEND: begin
        // A handshake on the expiry cycle takes precedence over the timeout.
        if (w_hs) begin
          w_tx_start_nxt  = 1'b1;
          w_tx_data_nxt   = w_owner_data;
          w_last_flag_nxt = req_last[r_owner];
          w_cnt_nxt       = '0;
          w_state_nxt     = S_WAIT_START;
        end else if (!req_valid[r_owner]) begin
          if (r_cnt == TO_LAST) begin
            w_lock_to_nxt    = 1'b1;
            w_last_grant_nxt = r_owner;
            w_grant_nxt      = '0;
            w_cnt_nxt        = '0;
            w_state_nxt      = S_IDLE;
          end else begin
            w_cnt_nxt = r_cnt + 1'b1;
          end
        end
      end
      S_WAIT_START: w_state_nxt = S_WAIT_DONE;
      S_WAIT_DONE: begin
        if (!tx_busy) begin
          if (r_last_flag) begin
            w_last_grant_nxt = r_owner;
            w_grant_nxt      = '0;
            w_state_nxt      = S_IDLE;
          end else begin
            w_state_nxt = S_SEND;
          end
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state      <= S_IDLE;
      r_grant      <= '0;
      r_owner      <= '0;
      r_last_grant <= LAST_IDX;
      r_cnt        <= '0;
      r_last_flag  <= 1'b0;
      r_tx_start   <= 1'b0;
      r_tx_data    <= 8'h00;
      r_lock_to    <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_grant      <= w_grant_nxt;
      r_owner      <= w_owner_nxt;
      r_last_grant <= w_last_grant_nxt;
      r_cnt        <= w_cnt_nxt;
      r_last_flag  <= w_last_flag_nxt;
      r_tx_start   <= w_tx_start_nxt;
      r_tx_data    <= w_tx_data_nxt;
      r_lock_to    <= w_lock_to_nxt;
    end
  end

  assign grant        = r_grant;
  assign tx_start     = r_tx_start;
  assign tx_data      = r_tx_data;
  assign lock_timeout = r_lock_to;
  assign dbg_state    = r_state;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter: expected TX bytes and grant order are
// queued up front and a negedge monitor pops and compares them as they appear.
`timescale 1ns/1ps
module tb_uart_tx_arbiter;

  localparam int NR    = 2;
  localparam int FRAME = 10;
  localparam logic [1:0] ST_IDLE = 2'd0, ST_SEND = 2'd1, ST_WDONE = 2'd3;

  logic          clk = 1'b0;
  logic          reset;
  logic [NR-1:0] req_valid;
  logic [8*NR-1:0] req_data;
  logic [NR-1:0] req_last;
  logic [NR-1:0] req_ready;
  logic [NR-1:0] grant;
  logic          tx_start;
  logic [7:0]    tx_data;
  logic          tx_busy;
  logic          lock_timeout;
  logic [1:0]    dbg_state;

  logic          force_busy;
  int            busy_cnt;
  int            cyc;
  int            total = 0;
  int            bad   = 0;
  int            rdy_viol = 0;
  logic          prev_tx_start = 1'b0;
  logic [NR-1:0] prev_grant = '0;

  logic [7:0]    exp_q[$];
  logic [NR-1:0] exp_g_q[$];

  uart_tx_arbiter #(.NUM_REQ(NR), .LOCK_TIMEOUT(16), .TO_W(5)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_data(req_data),
    .req_last(req_last), .req_ready(req_ready), .grant(grant),
    .tx_start(tx_start), .tx_data(tx_data), .tx_busy(tx_busy),
    .lock_timeout(lock_timeout), .dbg_state(dbg_state)
  );

  // ---------------- clock / reset / UART model ----------------
  always #5 clk = ~clk;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      busy_cnt <= 0;
      cyc      <= 0;
    end else begin
      cyc <= cyc + 1;
      if (tx_start)          busy_cnt <= FRAME;
      else if (busy_cnt != 0) busy_cnt <= busy_cnt - 1;
    end
  end
  assign tx_busy = (busy_cnt != 0) || force_busy;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time expired, required completion");
    $fatal(1);
  end

  // ---------------- checking helpers ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h, required %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- monitor / scoreboard ----------------
  always @(negedge clk) begin
    if (!reset) begin
      if (tx_start) begin
        check("tx_start_spacing", {30'd0, prev_tx_start, tx_busy}, 32'd0);
        if (exp_q.size() == 0) begin
          total++; bad++;
          $display("FAIL tx_unexpected: got %0h, required no byte", tx_data);
        end else begin
          check("tx_data", tx_data, exp_q.pop_front());
        end
      end
      if (grant != '0 && prev_grant == '0) begin
        if (exp_g_q.size() == 0) begin
          total++; bad++;
          $display("FAIL grant_unexpected: got %0b, required no grant", grant);
        end else begin
          check("grant_order", grant, exp_g_q.pop_front());
        end
      end
      if (((req_ready & ~(grant & req_valid)) != '0) || (tx_busy && req_ready != '0))
        rdy_viol++;
    end
    prev_tx_start = tx_start;
    prev_grant    = grant;
  end

  // ---------------- driver tasks ----------------
  task automatic send_byte(input int r, input logic [7:0] d, input logic l);
    int n;
    @(posedge clk); #1;
    req_valid[r] = 1'b1;
    req_data[8*r +: 8] = d;
    req_last[r] = l;
    n = 0;
    @(negedge clk);
    while (!req_ready[r] && n < 2000) begin
      n++;
      @(negedge clk);
    end
    if (!req_ready[r]) begin
      total++; bad++;
      $display("FAIL handshake_timeout: requester %0d byte %0h never accepted", r, d);
    end
    @(posedge clk); #1;
    req_valid[r] = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    int n;
    n = 0;
    @(negedge clk);
    while ((dbg_state != ST_IDLE || grant != '0) && n < 300) begin
      n++;
      @(negedge clk);
    end
    check(name, {28'd0, grant, dbg_state}, 32'd0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int t0, n;
    int bp_viol;
    reset = 1'b1; force_busy = 1'b0;
    req_valid = '0; req_data = '0; req_last = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_grant", grant, 0);
    check("rst_tx_start", tx_start, 0);
    check("rst_tx_data", tx_data, 8'h00);
    check("rst_lock_to", lock_timeout, 0);
    check("rst_state", dbg_state, ST_IDLE);
    @(negedge clk); reset = 1'b0;

    // Single one-byte packet from requester 0.
    exp_q.push_back(8'h41); exp_g_q.push_back(2'b01);
    @(posedge clk); #1;
    req_valid[0] = 1'b1; req_data[7:0] = 8'h41; req_last[0] = 1'b1;
    @(negedge clk);
    check("single_grant_before", grant, 2'b00);
    @(negedge clk);
    check("single_grant_latency", grant, 2'b01);
    check("single_ready", req_ready, 2'b01);
    @(posedge clk); #1;
    req_valid[0] = 1'b0;
    wait_idle("single_release");

    // Packet lock: "OK\n" from requester 0 while requester 1 waits with 0x55.
    exp_q.push_back(8'h4F); exp_q.push_back(8'h4B);
    exp_q.push_back(8'h0A); exp_q.push_back(8'h55);
    exp_g_q.push_back(2'b01); exp_g_q.push_back(2'b10);
    fork
      begin
        send_byte(0, 8'h4F, 1'b0);
        send_byte(0, 8'h4B, 1'b0);
        send_byte(0, 8'h0A, 1'b1);
      end
      begin
        repeat (3) @(posedge clk);
        send_byte(1, 8'h55, 1'b1);
      end
    join
    wait_idle("lock_release");

    // Round-robin with both requesters continuously valid.
    exp_q.push_back(8'hA0); exp_q.push_back(8'hB0);
    exp_q.push_back(8'hA1); exp_q.push_back(8'hB1);
    exp_g_q.push_back(2'b01); exp_g_q.push_back(2'b10);
    exp_g_q.push_back(2'b01); exp_g_q.push_back(2'b10);
    fork
      begin send_byte(0, 8'hA0, 1'b1); send_byte(0, 8'hA1, 1'b1); end
      begin send_byte(1, 8'hB0, 1'b1); send_byte(1, 8'hB1, 1'b1); end
    join
    wait_idle("rr_release");

    // Lock timeout: owner goes quiet after a non-last byte, requester 1 pending.
    exp_q.push_back(8'h11); exp_q.push_back(8'h22);
    exp_g_q.push_back(2'b01); exp_g_q.push_back(2'b10);
    send_byte(0, 8'h11, 1'b0);
    req_valid[1] = 1'b1; req_data[15:8] = 8'h22; req_last[1] = 1'b1;
    n = 0;
    @(negedge clk);
    while (dbg_state != ST_SEND && n < 100) begin n++; @(negedge clk); end
    check("to_reenter_send", dbg_state, ST_SEND);
    t0 = cyc;
    n = 0;
    while (!lock_timeout && n < 60) begin n++; @(negedge clk); end
    check("to_latency", cyc - t0, 16);
    check("to_grant_released", grant, 2'b00);
    check("to_state_idle", dbg_state, ST_IDLE);
    @(negedge clk);
    check("to_pulse_width", lock_timeout, 0);
    check("to_next_grant", grant, 2'b10);
    n = 0;
    while (!req_ready[1] && n < 100) begin n++; @(negedge clk); end
    @(posedge clk); #1;
    req_valid[1] = 1'b0;
    wait_idle("to_release");

    // Reset while the owner is in WAIT_DONE mid-packet.
    exp_q.push_back(8'h44); exp_g_q.push_back(2'b10);
    send_byte(1, 8'h44, 1'b0);
    n = 0;
    @(negedge clk);
    while (dbg_state != ST_WDONE && n < 20) begin n++; @(negedge clk); end
    check("mid_wait_done", dbg_state, ST_WDONE);
    @(posedge clk); #2;
    reset = 1'b1;
    #1;
    check("async_rst_grant", grant, 0);
    check("async_rst_state", dbg_state, ST_IDLE);
    check("async_rst_tx_data", tx_data, 8'h00);
    check("async_rst_tx_start", tx_start, 0);
    check("async_rst_lock_to", lock_timeout, 0);
    @(negedge clk); reset = 1'b0;
    exp_q.push_back(8'h66); exp_q.push_back(8'h77);
    exp_g_q.push_back(2'b01); exp_g_q.push_back(2'b10);
    fork
      send_byte(0, 8'h66, 1'b1);
      send_byte(1, 8'h77, 1'b1);
    join
    wait_idle("post_rst_release");

    // Backpressure: UART busy for 500 cycles while the owner is valid.
    exp_q.push_back(8'h88); exp_g_q.push_back(2'b01);
    @(posedge clk); #1;
    force_busy = 1'b1;
    req_valid[0] = 1'b1; req_data[7:0] = 8'h88; req_last[0] = 1'b1;
    bp_viol = 0;
    repeat (500) begin
      @(negedge clk);
      if (req_ready != '0 || tx_start) bp_viol++;
    end
    check("bp_no_accept", bp_viol, 0);
    check("bp_state_send", dbg_state, ST_SEND);
    @(posedge clk); #1;
    force_busy = 1'b0;
    @(negedge clk);
    check("bp_first_free_ready", req_ready, 2'b01);
    @(posedge clk); #1;
    req_valid[0] = 1'b0;
    @(negedge clk);
    check("bp_tx_start", tx_start, 1);
    wait_idle("bp_release");

    repeat (5) @(negedge clk);
    check("exp_q_drained", exp_q.size(), 0);
    check("exp_g_drained", exp_g_q.size(), 0);
    check("ready_rule", rdy_viol, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
- Shares the single UART byte transmitter (TX pin path) between NUM_REQ byte-stream requesters, e.g. cmd_handler replies and an asynchronous status/event reporter.
- Arbitration is round-robin at packet granularity. The grant is locked to one requester until it transfers a byte flagged last, so packets are never interleaved on TX.
- Sits between the requesters and the UART transmitter inside the top-level design.

Parameters:
- NUM_REQ, 2, number of requesters (2..4).
- LOCK_TIMEOUT, 1_000_000, idle cycles a locked requester may hold the grant with req_valid low before forced release; at 12 MHz this is about 83 ms.
- TO_W, 20, width of the timeout counter; must satisfy 2^TO_W > LOCK_TIMEOUT.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- req_valid  in  NUM_REQ  requester i has a byte on req_data.
- req_data  in  8*NUM_REQ  byte of requester i at bits [8i+7:8i].
- req_last  in  NUM_REQ  byte of requester i is the final byte of its packet.
- req_ready  out  NUM_REQ  byte of requester i accepted this cycle (combinational).
- grant  out  NUM_REQ  one-hot current owner; all zero when idle (registered).
- tx_start  out  1  one-cycle pulse to the UART transmitter (registered).
- tx_data  out  8  byte for the UART transmitter; stable from tx_start until the next tx_start.
- tx_busy  in  1  UART transmitter is shifting a frame.
- lock_timeout  out  1  one-cycle pulse when a lock is force-released.

Behaviour:
- Reset (asynchronous, any state):
  - state=IDLE, grant=0, tx_start=0, tx_data=8'h00, lock_timeout=0.
  - Timeout counter=0; last_grant index=NUM_REQ-1, so requester 0 wins first.
  - Reset mid-byte or mid-packet discards the lock. The UART frame already started is not the arbiter's concern.
- States: IDLE, SEND, WAIT_START, WAIT_DONE.
- IDLE:
  - If any req_valid bit is set, pick the first set bit scanning last_grant+1, last_grant+2, ... with wrap modulo NUM_REQ.
  - Register grant one-hot for that bit and go to SEND. Latency from req_valid to grant is 1 cycle.
  - req_ready is all zero in IDLE.
- SEND, owner g:
  - req_ready[g] = req_valid[g] & ~tx_busy. All other req_ready bits are 0.
  - On handshake (req_valid[g] & req_ready[g]):
    - Next cycle: tx_start=1, tx_data=req_data[g]. Latch last_flag=req_last[g]. Clear the timeout counter. Go to WAIT_START.
  - If req_valid[g]=0: increment the timeout counter.
  - When the counter reaches LOCK_TIMEOUT-1 with req_valid[g] still low:
    - Pulse lock_timeout, last_grant=g, grant=0, go to IDLE.
  - A handshake in the same cycle as counter expiry wins: the byte is sent and no timeout fires.
- WAIT_START:
  - tx_start returns to 0.
  - Ignore tx_busy for exactly this one cycle (the UART raises busy the cycle after start). Go to WAIT_DONE.
- WAIT_DONE:
  - Wait for tx_busy=0.
  - Then, if last_flag=1: last_grant=g, grant=0, go to IDLE.
  - Otherwise return to SEND with the grant held.
- Throughput: at most one byte per UART frame. No byte is accepted while tx_busy=1.
- Fairness: a requester that keeps req_valid high is served again only after every other pending requester has had one packet.
- Requesters that are not granted may change req_data/req_last freely. The owner must hold req_data/req_last stable while req_valid=1 and req_ready=0.
- Simultaneous requests in IDLE resolve by round-robin order only. There is no fixed priority.
- Single-byte packet (req_last=1 on the first byte) takes SEND -> WAIT_START -> WAIT_DONE -> IDLE.
- tx_start is never asserted while tx_busy=1 or in two consecutive cycles.

Test Plan:
- Reset then single request: req_valid=01, req_data[7:0]=8'h41, req_last=1.
  - Required: grant=01 one cycle later; req_ready[0] pulses; tx_start pulses with tx_data=8'h41.
  - After the UART model drops busy: grant=00, state IDLE.
- Packet lock: requester 0 sends "OK\n" (last on 8'h0A) while requester 1 holds req_valid from cycle 3 with 8'h55.
  - Required: TX order 4F,4B,0A,55; req_ready[1]=0 until grant=10.
- Round-robin: both requesters continuously valid with 1-byte packets.
  - Required: grant sequence 01,10,01,10; no requester is granted twice in a row.
- Lock timeout with LOCK_TIMEOUT=16: requester 0 sends a non-last byte, then drops req_valid.
  - Required: lock_timeout pulses exactly 16 cycles after entering SEND; grant=00; a pending requester 1 is granted on the next cycle.
- Reset mid-packet: assert reset in WAIT_DONE.
  - Required: all outputs at reset values immediately, without waiting for a clock edge.
  - After release, requester 0 has priority regardless of the previous owner.
- Backpressure: hold tx_busy=1 for 500 cycles in SEND with req_valid=1.
  - Required: req_ready=0 and no tx_start throughout; byte accepted the first cycle tx_busy=0.
